// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage.
//   Registers the decoded instruction coming out of ID and presents forwarded
//   operands to EX (ALU + srai barrel shifter). Also detects load-use hazards
//   (stall_o back to IF/ID) and turns flushed/stalled/invalid slots into bubbles.
// Ports:
//   clk_i, rst_i                 clock (rising), async active-high reset
//   id_*_i                       decoded instruction from ID
//   flush_i                      taken branch, squash the instruction entering EX
//   exmem_*_i, memwb_*_i         writeback sources for operand forwarding
//   stall_o                      load-use hold request for PC and IF/ID
//   ex_*_o                       registered / forwarded values for EX
// Control bundle layout: {alu_ctrl[3:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg}

// One forwarding mux per source operand. The youngest in-flight writer
// (EX/MEM) has priority over MEM/WB. A writer to x0 is never a source.
module id_ex_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            exmem_we_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic            memwb_we_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] data_o
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_we_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs_i);
  assign hit_memwb = memwb_we_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_i);

  always_comb begin
    data_o = reg_data_i;
    if (hit_exmem)      data_o = exmem_data_i;
    else if (hit_memwb) data_o = memwb_data_i;
  end
endmodule

module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              exmem_we_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic              memwb_we_i,
  input  logic [4:0]        memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_op1_o,
  output logic [XLEN-1:0]   ex_op2_o,
  output logic [4:0]        ex_shamt_o,
  output logic [XLEN-1:0]   ex_store_data_o,
  output logic [4:0]        ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o
);
  localparam int NUM_OPS    = 2;
  localparam int CB_ALU_SRC = 4;
  localparam int CB_MEM_RD  = 2;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t stage_q, stage_d;
  logic  bubble;

  // Load in EX whose destination is read by the instruction in ID.
  assign stall_o = stage_q.valid && stage_q.ctrl[CB_MEM_RD] && (stage_q.rd != 5'd0) &&
                   id_valid_i && ((stage_q.rd == id_rs1_i) || (stage_q.rd == id_rs2_i));

  assign bubble = flush_i || stall_o || !id_valid_i;

  // A bubble only clears the fields that cause side effects; operand data
  // is held since nothing downstream acts on it with ctrl=0.
  always_comb begin
    stage_d = stage_q;
    if (bubble) begin
      stage_d.valid = 1'b0;
      stage_d.ctrl  = '0;
      stage_d.rd    = 5'd0;
    end else begin
      stage_d.valid    = 1'b1;
      stage_d.pc       = id_pc_i;
      stage_d.rs1_data = id_rs1_data_i;
      stage_d.rs2_data = id_rs2_data_i;
      stage_d.imm      = id_imm_i;
      stage_d.rs1      = id_rs1_i;
      stage_d.rs2      = id_rs2_i;
      stage_d.rd       = id_rd_i;
      stage_d.ctrl     = id_ctrl_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  // Operand forwarding: index 0 = rs1, index 1 = rs2.
  logic [NUM_OPS-1:0][4:0]      op_rs;
  logic [NUM_OPS-1:0][XLEN-1:0] op_reg, op_fwd;

  assign op_rs  = {stage_q.rs2, stage_q.rs1};
  assign op_reg = {stage_q.rs2_data, stage_q.rs1_data};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN)) u_fwd (
      .rs_i        (op_rs[g]),
      .reg_data_i  (op_reg[g]),
      .exmem_we_i  (exmem_we_i),
      .exmem_rd_i  (exmem_rd_i),
      .exmem_data_i(exmem_data_i),
      .memwb_we_i  (memwb_we_i),
      .memwb_rd_i  (memwb_rd_i),
      .memwb_data_i(memwb_data_i),
      .data_o      (op_fwd[g])
    );
  end

  assign ex_valid_o      = stage_q.valid;
  assign ex_pc_o         = stage_q.pc;
  assign ex_rd_o         = stage_q.rd;
  assign ex_ctrl_o       = stage_q.ctrl;
  assign ex_op1_o        = op_fwd[0];
  assign ex_store_data_o = op_fwd[1];
  assign ex_op2_o        = stage_q.ctrl[CB_ALU_SRC] ? stage_q.imm : op_fwd[1];
  // Shifter uses the low five bits only; no range check on the upper bits.
  assign ex_shamt_o      = ex_op2_o[4:0];
endmodule
